// File: rtl/ctrl_fetch.sv
// ctrl_fetch: PC sequencer that fetches from an async-read instruction memory into a registered valid/ready output slot.
// Latency: enable high at edge 1 moves to RUN, first fetch registered at edge 2; then one fetch per cycle; redirect costs one bubble.
// Backpressure: out_ready low with a held fetch freezes pc and the output slot; out_ready has no combinational path to any output.
// Optional: define CTRL_FETCH_FAULT_EN to trap misaligned or out-of-range PCs into the FAULT state.
module ctrl_fetch #(
    parameter int unsigned DEPTH_W  = 5,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic [DEPTH_W-1:0] im_addr,
    input  logic [31:0]        im_rd,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic [31:0]        out_pc,
    output logic               fault,
    output logic [31:0]        fetch_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic        fault_q, fault_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;

    logic handshake;
    logic slot_free;
    logic pc_bad;

    assign handshake = out_valid_q && out_ready;
    assign slot_free = !out_valid_q || out_ready;

`ifdef CTRL_FETCH_FAULT_EN
    // A PC is fetchable only if word aligned and inside the memory window.
    assign pc_bad = (pc_q[1:0] != 2'b00) || (pc_q[31:DEPTH_W+2] != '0);
`else
    // Without fault checking every PC is fetched; high bits simply wrap through im_addr.
    assign pc_bad = 1'b0;
`endif

    // Memory word address comes straight from the PC register; byte offset and high bits dropped.
    assign im_addr   = pc_q[DEPTH_W+1:2];
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_pc    = out_pc_q;
    assign fault     = fault_q;
    assign fetch_cnt = fetch_cnt_q;

    // Next-state: redirect wins over everything, otherwise the FSM decides whether to load the slot.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q && !handshake;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        fault_d     = fault_q;
        fetch_cnt_d = fetch_cnt_q + {31'd0, handshake};

        if (redirect_valid) begin
            // Drop whatever is held; the transfer completing this edge is still counted above.
            pc_d        = redirect_pc;
            out_valid_d = 1'b0;
            if (state_q == ST_FAULT) begin
                state_d = ST_RUN;
                fault_d = 1'b0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (en) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!en) begin
                        state_d = ST_IDLE;
                    end else if (slot_free) begin
                        if (pc_bad) begin
                            state_d = ST_FAULT;
                            fault_d = 1'b1;
                        end else begin
                            out_instr_d = im_rd;
                            out_pc_d    = pc_q;
                            out_valid_d = 1'b1;
                            pc_d        = pc_q + 32'd4;
                        end
                    end
                end
                ST_FAULT: begin
                    // Parked until a redirect or reset; a held fetch can still drain.
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers; reset discards any pending fetch immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_instr_q <= 32'd0;
            out_pc_q    <= 32'd0;
            fault_q     <= 1'b0;
            fetch_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            fault_q     <= fault_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

endmodule

// File: tb/tb_ctrl_fetch.sv
// tb_ctrl_fetch: drives ctrl_fetch against a small instruction memory and scores each handshake against a queue of expected fetches.
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
// Expected fetches are pushed as each scenario is set up and popped whenever decode accepts one.
module tb_ctrl_fetch;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_t;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [4:0]  im_addr;
    logic [31:0] im_rd;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;
    logic [31:0] fetch_cnt;

    logic [31:0] imem [32];
    fetch_t      sb [$];
    int          n_chk;
    int          n_pass;

    ctrl_fetch #(
        .DEPTH_W (5),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .im_addr       (im_addr),
        .im_rd         (im_rd),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .fault         (fault),
        .fetch_cnt     (fetch_cnt)
    );

    assign im_rd = imem[im_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        logic [4:0] w;
        w = pc[6:2];
        return imem[w];
    endfunction

    task automatic push_pc(input logic [31:0] pc);
        fetch_t e;
        e.pc    = pc;
        e.instr = word_at(pc);
        sb.push_back(e);
    endtask

    // Score a transfer if one completes at the coming edge, then advance one full cycle.
    task automatic cycle();
        fetch_t e;
        if (out_valid && out_ready) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("hs_pc", out_pc, e.pc);
                chk("hs_instr", out_instr, e.instr);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        for (int i = 0; i < 32; i++) imem[i] = 32'hA000_0000 + 32'(i) * 32'h0101;
        imem[0] = 32'h00300413;
        imem[1] = 32'h00100493;

        rst_n          = 1'b0;
        en             = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        #2;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_cnt", fetch_cnt, 32'd0);
        chk("rst_imaddr", 32'(im_addr), 32'd0);

        // Start-up: RUN after edge 1, word0 after edge 2, word1 after edge 3.
        @(negedge clk);
        rst_n     = 1'b1;
        en        = 1'b1;
        out_ready = 1'b1;
        push_pc(32'h0); push_pc(32'h4); push_pc(32'h8); push_pc(32'hC);
        cycle();
        chk("start_e1_valid", 32'(out_valid), 32'd0);
        cycle();
        chk("start_e2_valid", 32'(out_valid), 32'd1);
        chk("start_e2_instr", out_instr, 32'h00300413);
        chk("start_e2_pc", out_pc, 32'h0);
        chk("start_e2_cnt", fetch_cnt, 32'd0);
        cycle();
        chk("start_e3_instr", out_instr, 32'h00100493);
        chk("start_e3_pc", out_pc, 32'h4);
        chk("start_e3_cnt", fetch_cnt, 32'd1);

        // Stall three cycles holding the fetch at pc 8.
        cycle();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_pc", out_pc, 32'h8);
            chk("stall_imaddr", 32'(im_addr), 32'd3);
            chk("stall_cnt", fetch_cnt, 32'd2);
        end
        out_ready = 1'b1;
        cycle();
        chk("unstall_pc", out_pc, 32'hC);
        chk("unstall_cnt", fetch_cnt, 32'd3);

        // Redirect to 0x40 while pc 12 is being accepted: one bubble, transfer still counted.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        cycle();
        redirect_valid = 1'b0;
        chk("redir_bubble", 32'(out_valid), 32'd0);
        chk("redir_cnt", fetch_cnt, 32'd4);
        push_pc(32'h40);
        cycle();
        chk("redir_valid", 32'(out_valid), 32'd1);
        chk("redir_pc", out_pc, 32'h40);
        chk("redir_instr", out_instr, imem[16]);

        // Halt: bring pc 20 into the slot unaccepted, then drop enable.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h14;
        cycle();
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        push_pc(32'h14);
        cycle();
        chk("halt_pre_pc", out_pc, 32'h14);
        en = 1'b0;
        cycle();
        chk("halt_held_valid", 32'(out_valid), 32'd1);
        chk("halt_held_pc", out_pc, 32'h14);
        out_ready = 1'b1;
        cycle();
        chk("halt_drain_valid", 32'(out_valid), 32'd0);
        chk("halt_drain_cnt", fetch_cnt, 32'd6);
        chk("halt_imaddr", 32'(im_addr), 32'd6);
        cycle();
        chk("halt_idle_valid", 32'(out_valid), 32'd0);
        chk("halt_idle_imaddr", 32'(im_addr), 32'd6);
        en = 1'b1;
        push_pc(32'h18);
        cycle();
        chk("resume_e1_valid", 32'(out_valid), 32'd0);
        cycle();
        chk("resume_pc", out_pc, 32'h18);

        // Last word of memory, then run past the end.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h7C;
        cycle();
        redirect_valid = 1'b0;
        push_pc(32'h7C);
        cycle();
        chk("top_pc", out_pc, 32'h7C);
        chk("top_instr", out_instr, imem[31]);
        chk("top_imaddr", 32'(im_addr), 32'd0);
`ifdef CTRL_FETCH_FAULT_EN
        cycle();
        chk("fault_set", 32'(fault), 32'd1);
        chk("fault_valid", 32'(out_valid), 32'd0);
        cycle();
        cycle();
        chk("fault_still_idle", 32'(out_valid), 32'd0);
        chk("fault_still_set", 32'(fault), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        cycle();
        redirect_valid = 1'b0;
        chk("fault_clear", 32'(fault), 32'd0);
        push_pc(32'h0);
        cycle();
        chk("fault_recover_pc", out_pc, 32'h0);
        chk("fault_recover_instr", out_instr, 32'h00300413);
`else
        push_pc(32'h80);
        cycle();
        chk("wrap_pc", out_pc, 32'h80);
        chk("wrap_instr", out_instr, 32'h00300413);
        chk("wrap_fault", 32'(fault), 32'd0);
`endif

        // Asynchronous reset between edges with a fetch held in the slot.
        chk("prereset_valid", 32'(out_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_instr", out_instr, 32'd0);
        chk("arst_pc", out_pc, 32'd0);
        chk("arst_cnt", fetch_cnt, 32'd0);
        chk("arst_fault", 32'(fault), 32'd0);
        chk("arst_imaddr", 32'(im_addr), 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        push_pc(32'h0);
        cycle();
        cycle();
        chk("post_reset_valid", 32'(out_valid), 32'd1);
        chk("post_reset_pc", out_pc, 32'h0);
        cycle();
        chk("post_reset_cnt", fetch_cnt, 32'd1);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
